// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single memory port between the CPU and a DMA/loader requester.
// Latency: grants are registered, 1 cycle after a request is sampled in IDLE; CPU<->DMA handover has no idle gap.
// Backpressure: requesters hold Req until Gnt; burst limit pre-empts a contended owner unless DMA holds dmaLock.
module mem_bus_arbiter #(
   parameter int M         = 16,
   parameter int MAX_BURST = 8,
   localparam int CW       = ($clog2(MAX_BURST) > 0) ? $clog2(MAX_BURST) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cpuReq,
   input  logic [M-1:0] cpuAddr,
   input  logic [M-1:0] cpuWrite,
   input  logic         cpuWE,
   output logic         cpuGnt,
   output logic [M-1:0] cpuRead,
   input  logic         dmaReq,
   input  logic         dmaLock,
   input  logic [M-1:0] dmaAddr,
   input  logic [M-1:0] dmaWrite,
   input  logic         dmaWE,
   output logic         dmaGnt,
   output logic [M-1:0] dmaRead,
   output logic [M-1:0] memAddr,
   output logic [M-1:0] memWrite,
   output logic         memWE,
   input  logic [M-1:0] memRead,
   output logic [1:0]   busOwner
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CPU  = 2'b01,
      DMA  = 2'b10
   } state_t;

   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

   state_t          state;
   state_t          nextState;
   logic [CW-1:0]   cnt;
   logic            lastWasDma;
   logic            burstDone;

   assign burstDone = (cnt == CNT_MAX);

   // Read data goes to both sides untouched; each requester qualifies it with its own grant.
   assign cpuRead = memRead;
   assign dmaRead = memRead;

   // Next owner: round-robin on ties from IDLE, release on Req drop, burst-limit pre-emption.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (cpuReq && dmaReq) nextState = lastWasDma ? CPU : DMA;
            else if (cpuReq)      nextState = CPU;
            else if (dmaReq)      nextState = DMA;
         end
         CPU: begin
            if (!cpuReq)                nextState = dmaReq ? DMA : IDLE;
            else if (dmaReq && burstDone) nextState = DMA;
         end
         DMA: begin
            if (!dmaReq)                             nextState = cpuReq ? CPU : IDLE;
            else if (cpuReq && !dmaLock && burstDone) nextState = CPU;
         end
         default: nextState = IDLE;
      endcase
   end

   // State register with registered grants, owner, round-robin memory and saturating burst counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cpuGnt     <= 1'b0;
         dmaGnt     <= 1'b0;
         busOwner   <= 2'b00;
         cnt        <= '0;
         lastWasDma <= 1'b1;
      end else begin
         state    <= nextState;
         cpuGnt   <= (nextState == CPU);
         dmaGnt   <= (nextState == DMA);
         busOwner <= nextState;
         if (nextState != state) begin
            cnt <= '0;
            if (nextState == CPU)      lastWasDma <= 1'b0;
            else if (nextState == DMA) lastWasDma <= 1'b1;
         end else if (state != IDLE && !burstDone) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // Memory port mux follows the current owner; a dropped Req suppresses the write in the same cycle.
   always_comb begin
      memAddr  = '0;
      memWrite = '0;
      memWE    = 1'b0;
      case (state)
         CPU: begin
            memAddr  = cpuAddr;
            memWrite = cpuWrite;
            memWE    = cpuWE & cpuReq;
         end
         DMA: begin
            memAddr  = dmaAddr;
            memWrite = dmaWrite;
            memWE    = dmaWE & dmaReq;
         end
         default: begin
            memAddr  = '0;
            memWrite = '0;
            memWE    = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single RCPU memory port (memAddr/memWrite/memWE/memRead) between the CPU and a DMA/loader requester. It uses a three-state FSM with registered grants, round-robin tie-breaking and a burst limit, and the DMA side can lock the bus. It sits between rcpu, the DMA engine and the memory.

Parameters:
M, 16, bus width (address and data)
MAX_BURST, 8, maximum consecutive granted cycles while the other side is waiting; minimum 1
CW, $clog2(MAX_BURST)>0 ? $clog2(MAX_BURST) : 1, burst counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
cpuReq  in  1  CPU requests the bus
cpuAddr  in  M  CPU address
cpuWrite  in  M  CPU write data
cpuWE  in  1  CPU write enable
cpuGnt  out  1  CPU owns the bus this cycle
cpuRead  out  M  read data to CPU
dmaReq  in  1  DMA requests the bus
dmaLock  in  1  DMA asks not to be pre-empted by the burst limit
dmaAddr  in  M  DMA address
dmaWrite  in  M  DMA write data
dmaWE  in  1  DMA write enable
dmaGnt  out  1  DMA owns the bus this cycle
dmaRead  out  M  read data to DMA
memAddr  out  M  memory address
memWrite  out  M  memory write data
memWE  out  1  memory write enable
memRead  in  M  memory read data
busOwner  out  2  owner: 00 idle, 01 CPU, 10 DMA

Behaviour:
- Reset (async, rst high) sets:
  - state = IDLE, cpuGnt = dmaGnt = 0, busOwner = 00, burst counter = 0.
  - lastOwner = DMA, so the CPU wins the first tie.
  - memAddr = 0, memWrite = 0, memWE = 0.
- Reset mid-operation drops the grant immediately. No write is issued after rst rises.
- Grant outputs:
  - cpuGnt = (state==CPU), dmaGnt = (state==DMA). Both are registered.
  - Grant latency is 1 cycle from a request sampled in IDLE.
  - Grants are never both high.
- Datapath mux is combinational from state:
  - CPU state: memAddr/memWrite come from cpu*, memWE = cpuWE & cpuReq.
  - DMA state: memAddr/memWrite come from dma*, memWE = dmaWE & dmaReq.
  - IDLE: memAddr = memWrite = 0, memWE = 0.
- memRead is fanned out unmodified to cpuRead and dmaRead at all times. Each requester qualifies it with its own Gnt.
- Requester rules:
  - Hold Req and keep signals stable until Gnt is seen.
  - An access takes effect on every cycle where Gnt and Req are both high.
  - Deasserting Req while granted suppresses memWE in that same cycle.
- FSM transitions, evaluated on each clk edge:
  - IDLE:
    - both Req → grant the side that is not lastOwner.
    - single Req → grant that side.
    - none → stay in IDLE.
  - CPU:
    - !cpuReq → DMA if dmaReq, else IDLE.
    - cpuReq & dmaReq & cnt==MAX_BURST-1 → DMA.
    - otherwise stay.
  - DMA:
    - !dmaReq → CPU if cpuReq, else IDLE.
    - dmaReq & cpuReq & !dmaLock & cnt==MAX_BURST-1 → CPU.
    - otherwise stay.
- Handover is direct CPU↔DMA with no idle gap cycle.
- lastOwner is updated on every entry into CPU or DMA.
- Burst counter:
  - Cleared on any state change.
  - Increments each cycle the state is held, saturating at MAX_BURST-1. It holds there while the owner continues, including a locked DMA.
- dmaLock only blocks burst-limit pre-emption. Dropping dmaReq always releases the bus.
- dmaLock deasserted while cnt is saturated and cpuReq is high → hand over to CPU at the next edge.
- MAX_BURST=1: under continuous contention, ownership alternates every cycle.
- busOwner is registered and tracks state.

Test Plan:
- Reset then idle: rst pulse mid-DMA write (dmaWE=1) → memWE=0 immediately; dmaGnt=0, busOwner=00 while rst high; rst low with no requests → stays IDLE.
- Single CPU request: cpuReq=1, cpuAddr=0x1234, cpuWE=1, cpuWrite=0xBEEF at cycle 0 → cpuGnt=1 at cycle 1; memAddr=0x1234, memWrite=0xBEEF, memWE=1; cpuReq drop → IDLE next cycle.
- Tie from reset: cpuReq=dmaReq=1 at the same edge → CPU granted first; after 8 cycles (MAX_BURST=8) DMA granted, then CPU again after 8 more; exactly one Gnt high every cycle.
- DMA lock: DMA granted, dmaLock=1, cpuReq=1 for 20 cycles → dmaGnt holds all 20; dmaLock=0 → cpuGnt=1 next edge.
- Early release: CPU granted, dmaReq=1, cpuReq dropped at cnt=3 → dmaGnt next cycle with no IDLE gap; memWE=0 in the cycle cpuReq is low.
- Read fan-out: memRead=0xA5A5 with DMA granted → dmaRead=cpuRead=0xA5A5 in the same cycle; MAX_BURST=1 build with constant contention → grants alternate every cycle.
